// File: rtl/alu_md_unit_if.sv
// Handshake and result bundle between the ID/EX register, the EX-stage execution unit and EX/MEM.
// The unit drives the slave side; the pipeline (or a testbench) drives the master side.
interface alu_md_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ALU_Control;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_Result;
    logic             Zero;
    logic             Overflow;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output in_valid, SrcA, SrcB, ALU_Control, flush, out_ready,
        input  in_ready, out_valid, ALU_Result, Zero, Overflow, HI, LO
    );

    modport slave (
        input  in_valid, SrcA, SrcB, ALU_Control, flush, out_ready,
        output in_ready, out_valid, ALU_Result, Zero, Overflow, HI, LO
    );
endinterface

// File: rtl/alu_md_unit.sv
// Handshaked EX-stage ALU with registered result plus iterative multiply/divide and HI/LO.
// Define ALU_DIV_EN to build the restoring divider; otherwise DIV/DIVU complete in one cycle with result 0.
module alu_md_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         reset,
    alu_md_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               outValid_q, outValid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               pend_q, pend_d;
    logic [WIDTH-1:0]   pendA_q, pendA_d;
    logic [WIDTH-1:0]   pendB_q, pendB_d;
    logic [3:0]         pendCtrl_q, pendCtrl_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               negRes_q, negRes_d;
`ifdef ALU_DIV_EN
    logic               negRem_q, negRem_d;
    logic               divZero_q, divZero_d;
    logic [WIDTH-1:0]   opA_q, opA_d;
`endif

    logic             outFree;
    logic             inReady;
    logic             accept;
    logic             isMulti;
    logic             signedOp;
    logic             lastStep;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;

    assign outFree  = !outValid_q || bus.out_ready;
    assign inReady  = (state_q == IDLE) && outFree;
    assign accept   = bus.in_valid && inReady && !bus.flush;
    assign signedOp = !bus.ALU_Control[0];
    assign lastStep = (cnt_q == LAST_STEP);
`ifdef ALU_DIV_EN
    assign isMulti  = (bus.ALU_Control[3:2] == 2'b11);
`else
    assign isMulti  = (bus.ALU_Control[3:2] == 2'b11) && !bus.ALU_Control[1];
`endif
    assign magA = (signedOp && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
    assign magB = (signedOp && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;

    // Single-cycle ops are captured into a one-entry stage and evaluated from it on the next edge.
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] aluRes;
    logic             aluOvf;

    assign sum   = pendA_q + pendB_q;
    assign diff  = pendA_q - pendB_q;
    assign shamt = pendB_q[SHW-1:0];

    always_comb begin
        aluRes = '0;
        aluOvf = 1'b0;
        case (pendCtrl_q)
            4'b0000: aluRes = pendA_q & pendB_q;
            4'b0001: aluRes = pendA_q | pendB_q;
            4'b0010: begin
                aluRes = sum;
                aluOvf = (pendA_q[WIDTH-1] == pendB_q[WIDTH-1]) && (sum[WIDTH-1] != pendA_q[WIDTH-1]);
            end
            4'b0011: aluRes = {{(WIDTH-1){1'b0}}, (pendA_q < pendB_q)};
            4'b0100: aluRes = ~(pendA_q | pendB_q);
            4'b0101: aluRes = pendA_q ^ pendB_q;
            4'b0110: begin
                aluRes = diff;
                aluOvf = (pendA_q[WIDTH-1] != pendB_q[WIDTH-1]) && (diff[WIDTH-1] != pendA_q[WIDTH-1]);
            end
            4'b0111: aluRes = {{(WIDTH-1){1'b0}}, ($signed(pendA_q) < $signed(pendB_q))};
            4'b1000: aluRes = pendA_q << shamt;
            4'b1001: aluRes = pendA_q >> shamt;
            4'b1010: aluRes = $signed(pendA_q) >>> shamt;
            default: aluRes = '0;
        endcase
    end

    // Shift-add multiplier on magnitudes: upper half accumulates, lower half shifts out the multiplier.
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [2*WIDTH-1:0] mulFinal;

    assign mulSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign mulNext  = {mulSum, prod_q[WIDTH-1:1]};
    assign mulFinal = negRes_q ? -mulNext : mulNext;

`ifdef ALU_DIV_EN
    // Restoring divider reusing prod_q as {remainder, quotient} and mcand_q as the divisor.
    logic [WIDTH:0]     remShift;
    logic [WIDTH:0]     remSub;
    logic               remGe;
    logic [2*WIDTH-1:0] divNext;
    logic [WIDTH-1:0]   quotFinal;
    logic [WIDTH-1:0]   remFinal;

    assign remShift  = prod_q[2*WIDTH-1:WIDTH-1];
    assign remSub    = remShift - {1'b0, mcand_q};
    assign remGe     = (remShift >= {1'b0, mcand_q});
    assign divNext   = {(remGe ? remSub[WIDTH-1:0] : remShift[WIDTH-1:0]), prod_q[WIDTH-2:0], remGe};
    assign quotFinal = divZero_q ? {WIDTH{1'b1}} :
                       (negRes_q ? -divNext[WIDTH-1:0] : divNext[WIDTH-1:0]);
    assign remFinal  = divZero_q ? opA_q :
                       (negRem_q ? -divNext[2*WIDTH-1:WIDTH] : divNext[2*WIDTH-1:WIDTH]);
`endif

    // Next-state and datapath update; flush overrides everything except HI/LO history.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        outValid_d = outValid_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        pend_d     = pend_q;
        pendA_d    = pendA_q;
        pendB_d    = pendB_q;
        pendCtrl_d = pendCtrl_q;
        mcand_d    = mcand_q;
        prod_d     = prod_q;
        negRes_d   = negRes_q;
`ifdef ALU_DIV_EN
        negRem_d   = negRem_q;
        divZero_d  = divZero_q;
        opA_d      = opA_q;
`endif

        if (outValid_q && bus.out_ready) begin
            outValid_d = 1'b0;
        end
        if (pend_q && outFree) begin
            result_d   = aluRes;
            ovf_d      = aluOvf;
            outValid_d = 1'b1;
            pend_d     = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (isMulti) begin
                        cnt_d    = '0;
                        mcand_d  = magB;
                        prod_d   = {{WIDTH{1'b0}}, magA};
                        negRes_d = signedOp && (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
`ifdef ALU_DIV_EN
                        negRem_d  = signedOp && bus.SrcA[WIDTH-1];
                        divZero_d = (bus.SrcB == '0);
                        opA_d     = bus.SrcA;
                        state_d   = bus.ALU_Control[1] ? DIV : MUL;
`else
                        state_d   = MUL;
`endif
                    end else begin
                        pend_d     = 1'b1;
                        pendA_d    = bus.SrcA;
                        pendB_d    = bus.SrcB;
                        pendCtrl_d = bus.ALU_Control;
                    end
                end
            end
            MUL: begin
                if (!lastStep || outFree) begin
                    cnt_d  = cnt_q + SHW'(1);
                    prod_d = mulNext;
                    if (lastStep) begin
                        hi_d       = mulFinal[2*WIDTH-1:WIDTH];
                        lo_d       = mulFinal[WIDTH-1:0];
                        result_d   = mulFinal[WIDTH-1:0];
                        ovf_d      = 1'b0;
                        outValid_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end
                end
            end
`ifdef ALU_DIV_EN
            DIV: begin
                if (!lastStep || outFree) begin
                    cnt_d  = cnt_q + SHW'(1);
                    prod_d = divNext;
                    if (lastStep) begin
                        hi_d       = remFinal;
                        lo_d       = quotFinal;
                        result_d   = quotFinal;
                        ovf_d      = 1'b0;
                        outValid_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (bus.flush) begin
            state_d    = IDLE;
            cnt_d      = '0;
            outValid_d = 1'b0;
            pend_d     = 1'b0;
            result_d   = result_q;
            ovf_d      = ovf_q;
            hi_d       = hi_q;
            lo_d       = lo_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            outValid_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            pend_q     <= 1'b0;
            pendA_q    <= '0;
            pendB_q    <= '0;
            pendCtrl_q <= '0;
            mcand_q    <= '0;
            prod_q     <= '0;
            negRes_q   <= 1'b0;
`ifdef ALU_DIV_EN
            negRem_q   <= 1'b0;
            divZero_q  <= 1'b0;
            opA_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            outValid_q <= outValid_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            pend_q     <= pend_d;
            pendA_q    <= pendA_d;
            pendB_q    <= pendB_d;
            pendCtrl_q <= pendCtrl_d;
            mcand_q    <= mcand_d;
            prod_q     <= prod_d;
            negRes_q   <= negRes_d;
`ifdef ALU_DIV_EN
            negRem_q   <= negRem_d;
            divZero_q  <= divZero_d;
            opA_q      <= opA_d;
`endif
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.out_valid  = outValid_q;
    assign bus.ALU_Result = result_q;
    assign bus.Zero       = (result_q == '0);
    assign bus.Overflow   = ovf_q;
    assign bus.HI         = hi_q;
    assign bus.LO         = lo_q;

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed self-checking bench for alu_md_unit; expectations are hand-computed constants.
// Divide vectors follow ALU_DIV_EN the same way the design does.
module tb_alu_md_unit;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        v;
    } aluVec_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } mdVec_t;

    logic        clk = 1'b0;
    logic        reset;
    int          nCompared = 0;
    int          nMismatched = 0;
    logic [31:0] expHi = 32'h0;
    logic [31:0] expLo = 32'h0;

    alu_md_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_md_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog simulation did not finish, required completion before 400us");
        $fatal(1, "[TB] watchdog");
    end

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one op at a negedge and returns at the negedge after the accepting edge.
    task automatic sendOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        bus.ALU_Control = op;
        bus.SrcA        = a;
        bus.SrcB        = b;
        bus.in_valid    = 1'b1;
        #1;
        while (!bus.in_ready && waited < 100) begin
            nextCycle();
            #1;
            waited++;
        end
        nCompared++;
        if (bus.in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL accept_timeout op=%b in_ready=%b required 1", op, bus.in_ready);
        end
        nextCycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic waitOut(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 100) begin
            nextCycle();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b1;
        bus.SrcA        = '0;
        bus.SrcB        = '0;
        bus.ALU_Control = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_out_valid got %b expected 0", bus.out_valid); end
        nCompared++; if (bus.ALU_Result !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_result got %h expected 0", bus.ALU_Result); end
        nCompared++; if (bus.Zero !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_zero got %b expected 1", bus.Zero); end
        nCompared++; if (bus.Overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_overflow got %b expected 0", bus.Overflow); end
        nCompared++; if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_hilo got %h/%h expected 0/0", bus.HI, bus.LO); end
        nCompared++; if (bus.in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_in_ready got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_add_overflow();
        int cycles;
        sendOp(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_early_valid got %b expected 0", bus.out_valid); end
        waitOut(cycles);
        nCompared++; if (cycles != 1) begin nMismatched++; $display("[TB] FAIL add_latency got %0d expected 1", cycles); end
        nCompared++; if (bus.ALU_Result !== 32'h8000_0000) begin nMismatched++; $display("[TB] FAIL add_result got %h expected 80000000", bus.ALU_Result); end
        nCompared++; if (bus.Overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL add_overflow got %b expected 1", bus.Overflow); end
        nCompared++; if (bus.Zero !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_zero got %b expected 0", bus.Zero); end
    endtask

    task automatic test_alu_ops();
        int      cycles;
        aluVec_t vecs [14];
        vecs = '{
            '{4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0},
            '{4'b0001, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1'b0},
            '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
            '{4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1},
            '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0},
            '{4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
            '{4'b0100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0},
            '{4'b0101, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0},
            '{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1},
            '{4'b0110, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0},
            '{4'b1000, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0},
            '{4'b1001, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0},
            '{4'b1010, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0},
            '{4'b1011, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 1'b0}
        };
        for (int i = 0; i < 14; i++) begin
            sendOp(vecs[i].op, vecs[i].a, vecs[i].b);
            waitOut(cycles);
            nCompared++; if (cycles != 1) begin nMismatched++; $display("[TB] FAIL alu_latency[%0d] got %0d expected 1", i, cycles); end
            nCompared++; if (bus.ALU_Result !== vecs[i].r) begin nMismatched++; $display("[TB] FAIL alu_result[%0d] op=%b got %h expected %h", i, vecs[i].op, bus.ALU_Result, vecs[i].r); end
            nCompared++; if (bus.Overflow !== vecs[i].v) begin nMismatched++; $display("[TB] FAIL alu_overflow[%0d] got %b expected %b", i, bus.Overflow, vecs[i].v); end
            nCompared++; if (bus.Zero !== (vecs[i].r == 32'h0)) begin nMismatched++; $display("[TB] FAIL alu_zero[%0d] got %b expected %b", i, bus.Zero, (vecs[i].r == 32'h0)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [31:0] rs  [4];
        ops = '{4'b0010, 4'b0110, 4'b0101, 4'b1000};
        as  = '{32'd1, 32'd10, 32'h0000_000F, 32'd3};
        bs  = '{32'd2, 32'd3, 32'h0000_0005, 32'd2};
        rs  = '{32'd3, 32'd7, 32'h0000_000A, 32'h0000_000C};
        bus.out_ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            if (i >= 2) begin
                nCompared++; if (bus.out_valid !== 1'b1 || bus.ALU_Result !== rs[i-2]) begin nMismatched++; $display("[TB] FAIL b2b_result[%0d] got valid=%b %h expected valid=1 %h", i - 2, bus.out_valid, bus.ALU_Result, rs[i-2]); end
            end
            if (i < 4) begin
                bus.ALU_Control = ops[i];
                bus.SrcA        = as[i];
                bus.SrcB        = bs[i];
                bus.in_valid    = 1'b1;
                #1;
                nCompared++; if (bus.in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_in_ready[%0d] got %b expected 1", i, bus.in_ready); end
            end else begin
                bus.in_valid = 1'b0;
            end
            nextCycle();
        end
    endtask

    task automatic test_mult();
        int     cycles;
        logic   readyLeak;
        mdVec_t vecs [3];
        vecs = '{
            '{4'b1100, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA},
            '{4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001},
            '{4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001}
        };
        for (int i = 0; i < 3; i++) begin
            sendOp(vecs[i].op, vecs[i].a, vecs[i].b);
            cycles    = 0;
            readyLeak = 1'b0;
            while (!bus.out_valid && cycles < 100) begin
                if (bus.in_ready) readyLeak = 1'b1;
                nextCycle();
                cycles++;
            end
            nCompared++; if (cycles != 32) begin nMismatched++; $display("[TB] FAIL mult_latency[%0d] got %0d expected 32", i, cycles); end
            nCompared++; if (readyLeak !== 1'b0) begin nMismatched++; $display("[TB] FAIL mult_in_ready[%0d] got high during op expected low", i); end
            nCompared++; if (bus.HI !== vecs[i].hi) begin nMismatched++; $display("[TB] FAIL mult_hi[%0d] got %h expected %h", i, bus.HI, vecs[i].hi); end
            nCompared++; if (bus.LO !== vecs[i].lo) begin nMismatched++; $display("[TB] FAIL mult_lo[%0d] got %h expected %h", i, bus.LO, vecs[i].lo); end
            nCompared++; if (bus.ALU_Result !== vecs[i].lo) begin nMismatched++; $display("[TB] FAIL mult_result[%0d] got %h expected %h", i, bus.ALU_Result, vecs[i].lo); end
            expHi = vecs[i].hi;
            expLo = vecs[i].lo;
        end
    endtask

    task automatic test_div();
        int     cycles;
        mdVec_t vecs [5];
        vecs = '{
            '{4'b1110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
            '{4'b1111, 32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF},
            '{4'b1110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD},
            '{4'b1111, 32'd100,       32'd7,         32'd2,         32'd14},
            '{4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000}
        };
        for (int i = 0; i < 5; i++) begin
            sendOp(vecs[i].op, vecs[i].a, vecs[i].b);
            waitOut(cycles);
`ifdef ALU_DIV_EN
            nCompared++; if (cycles != 32) begin nMismatched++; $display("[TB] FAIL div_latency[%0d] got %0d expected 32", i, cycles); end
            nCompared++; if (bus.HI !== vecs[i].hi) begin nMismatched++; $display("[TB] FAIL div_hi[%0d] got %h expected %h", i, bus.HI, vecs[i].hi); end
            nCompared++; if (bus.LO !== vecs[i].lo) begin nMismatched++; $display("[TB] FAIL div_lo[%0d] got %h expected %h", i, bus.LO, vecs[i].lo); end
            nCompared++; if (bus.ALU_Result !== vecs[i].lo) begin nMismatched++; $display("[TB] FAIL div_result[%0d] got %h expected %h", i, bus.ALU_Result, vecs[i].lo); end
            expHi = vecs[i].hi;
            expLo = vecs[i].lo;
`else
            nCompared++; if (cycles != 1) begin nMismatched++; $display("[TB] FAIL nodiv_latency[%0d] got %0d expected 1", i, cycles); end
            nCompared++; if (bus.ALU_Result !== 32'h0) begin nMismatched++; $display("[TB] FAIL nodiv_result[%0d] got %h expected 0", i, bus.ALU_Result); end
            nCompared++; if (bus.HI !== expHi || bus.LO !== expLo) begin nMismatched++; $display("[TB] FAIL nodiv_hilo[%0d] got %h/%h expected %h/%h", i, bus.HI, bus.LO, expHi, expLo); end
`endif
        end
    endtask

    task automatic test_backpressure();
        nextCycle();
        bus.out_ready = 1'b0;
        sendOp(4'b0110, 32'd5, 32'd5);
        nextCycle();
        nCompared++; if (bus.out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_valid got %b expected 1", bus.out_valid); end
        bus.ALU_Control = 4'b0010;
        bus.SrcA        = 32'd2;
        bus.SrcB        = 32'd3;
        bus.in_valid    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            nCompared++; if (bus.in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_in_ready[%0d] got %b expected 0", i, bus.in_ready); end
            nCompared++; if (bus.ALU_Result !== 32'h0 || bus.Zero !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_hold[%0d] got %h zero=%b expected 0 zero=1", i, bus.ALU_Result, bus.Zero); end
            nCompared++; if (bus.out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_valid_hold[%0d] got %b expected 1", i, bus.out_valid); end
            nextCycle();
        end
        bus.out_ready = 1'b1;
        #1;
        nCompared++; if (bus.in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_release_ready got %b expected 1", bus.in_ready); end
        nextCycle();
        bus.in_valid = 1'b0;
        nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_consumed got valid=%b expected 0", bus.out_valid); end
        nextCycle();
        nCompared++; if (bus.out_valid !== 1'b1 || bus.ALU_Result !== 32'd5) begin nMismatched++; $display("[TB] FAIL bp_next_result got valid=%b %h expected valid=1 00000005", bus.out_valid, bus.ALU_Result); end
    endtask

    task automatic test_flush();
        logic sawValid;
        nextCycle();
        sendOp(4'b1101, 32'd3, 32'd5);
        repeat (9) nextCycle();
        bus.flush = 1'b1;
        nextCycle();
        bus.flush = 1'b0;
        nCompared++; if (bus.out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_valid got %b expected 0", bus.out_valid); end
        nCompared++; if (bus.in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL flush_idle in_ready got %b expected 1", bus.in_ready); end
        nCompared++; if (bus.HI !== expHi || bus.LO !== expLo) begin nMismatched++; $display("[TB] FAIL flush_hilo got %h/%h expected %h/%h", bus.HI, bus.LO, expHi, expLo); end
        sawValid = 1'b0;
        repeat (40) begin
            nextCycle();
            if (bus.out_valid) sawValid = 1'b1;
        end
        nCompared++; if (sawValid !== 1'b0 || bus.HI !== expHi || bus.LO !== expLo) begin nMismatched++; $display("[TB] FAIL flush_discard got late valid=%b hilo=%h/%h expected 0 %h/%h", sawValid, bus.HI, bus.LO, expHi, expLo); end
        bus.ALU_Control = 4'b0010;
        bus.SrcA        = 32'd1;
        bus.SrcB        = 32'd1;
        bus.in_valid    = 1'b1;
        bus.flush       = 1'b1;
        nextCycle();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        sawValid = 1'b0;
        repeat (3) begin
            if (bus.out_valid) sawValid = 1'b1;
            nextCycle();
        end
        nCompared++; if (sawValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_ignores_input got valid=%b expected 0", sawValid); end
    endtask

    task automatic test_reset_mid_op();
        int   cycles;
        logic sawValid;
`ifdef ALU_DIV_EN
        sendOp(4'b1110, 32'd100, 32'd7);
`else
        sendOp(4'b1100, 32'd100, 32'd7);
`endif
        repeat (5) nextCycle();
        reset = 1'b1;
        #1;
        nCompared++; if (bus.out_valid !== 1'b0 || bus.ALU_Result !== 32'h0) begin nMismatched++; $display("[TB] FAIL rst_mid_out got valid=%b %h expected 0 0", bus.out_valid, bus.ALU_Result); end
        nCompared++; if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin nMismatched++; $display("[TB] FAIL rst_mid_hilo got %h/%h expected 0/0", bus.HI, bus.LO); end
        nCompared++; if (bus.Zero !== 1'b1 || bus.Overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_mid_flags got zero=%b ovf=%b expected 1 0", bus.Zero, bus.Overflow); end
        nCompared++; if (bus.in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst_mid_idle in_ready got %b expected 1", bus.in_ready); end
        @(negedge clk);
        reset = 1'b0;
        sawValid = 1'b0;
        repeat (40) begin
            nextCycle();
            if (bus.out_valid) sawValid = 1'b1;
        end
        nCompared++; if (sawValid !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin nMismatched++; $display("[TB] FAIL rst_mid_no_write got valid=%b hilo=%h/%h expected 0 0/0", sawValid, bus.HI, bus.LO); end
        sendOp(4'b0010, 32'd1, 32'd1);
        waitOut(cycles);
        nCompared++; if (cycles != 1 || bus.ALU_Result !== 32'd2) begin nMismatched++; $display("[TB] FAIL rst_mid_resume got latency=%0d %h expected 1 00000002", cycles, bus.ALU_Result); end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_add_overflow();
        test_alu_ops();
        test_back_to_back();
        test_mult();
        test_div();
        test_backpressure();
        test_flush();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
